// File: rtl/trace_pkg.sv
// Shared types and constants for the a0 trace buffer.
package trace_pkg;

   localparam int TRACE_WIDTH   = 32;
   localparam int TRACE_CYCLE_W = 32;

   localparam logic [15:0] DROP_MAX = 16'hFFFF;

   // One captured a0 transition at the default widths.
   typedef struct packed {
      logic [TRACE_WIDTH-1:0]   value;
      logic [TRACE_CYCLE_W-1:0] cycle;
   } trace_entry_t;

   // Saturating increment for the 16-bit drop counter.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == DROP_MAX) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/a0_trace_buffer_sync_fifo.sv
// Single-clock FIFO with a separate level counter. A push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter  int DATA_W = 64,
   parameter  int DEPTH  = 16,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int LVL_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              empty,
   output logic              full,
   output logic [LVL_W-1:0]  level
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [LVL_W-1:0]  cnt;
   logic              do_push;
   logic              do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == LVL_W'(DEPTH));
   assign do_pop  = pop && !empty;
   // When full, the write lands in the slot being read out this same cycle.
   assign do_push = push && (!full || do_pop);
   assign level   = cnt;
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Pointers wrap naturally; level tracks occupancy independently.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + LVL_W'(1);
            2'b01:   cnt <= cnt - LVL_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/a0_trace_buffer.sv
// Records every change of the CPU's a0 register with a cycle timestamp and
// queues the {value, cycle} pairs for a valid/ready consumer.
module a0_trace_buffer
   import trace_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 16,
   parameter int CYCLE_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [WIDTH-1:0]       a0,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_value,
   output logic [CYCLE_W-1:0]     out_cycle,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic [15:0]            drop_count
);

   localparam int DATA_W = WIDTH + CYCLE_W;

   logic [CYCLE_W-1:0] cycle_cnt;
   logic [WIDTH-1:0]   prev_a0;
   logic               first_flag;
   logic               detect;
   logic               popping;
   logic               full;
   logic               empty;
   logic               drop;
   logic [DATA_W-1:0]  head;

   // The first enabled cycle after reset always captures, whatever a0 is.
   assign detect  = en && (first_flag || (a0 != prev_a0));
   assign popping = out_valid && out_ready;
   assign drop    = detect && full && !popping;

   assign out_valid = !empty;
   assign out_value = head[DATA_W-1:CYCLE_W];
   assign out_cycle = head[CYCLE_W-1:0];

   // Free-running timestamp; wraps silently.
   always_ff @(posedge clk) begin
      if (rst) cycle_cnt <= '0;
      else     cycle_cnt <= cycle_cnt + CYCLE_W'(1);
   end

   // Change detector history; frozen while capture is disabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_a0    <= '0;
         first_flag <= 1'b1;
      end else if (en) begin
         prev_a0 <= a0;
         if (detect) first_flag <= 1'b0;
      end
   end

   // Sticky overflow and saturating drop tally.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (drop) begin
         overflow   <= 1'b1;
         drop_count <= sat_inc16(drop_count);
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (detect),
      .pop   (out_ready),
      .din   ({a0, cycle_cnt}),
      .dout  (head),
      .empty (empty),
      .full  (full),
      .level (level)
   );

endmodule

// File: doc/a0_trace_buffer.md
Name: a0_trace_buffer

Overview:
- Sits directly downstream of the pipelined CPU top and consumes its a0 output.
- Detects every change of a0 and timestamps it with a free-running cycle counter.
- Queues each {value, cycle} entry in a FIFO drained by the testbench or display logic over a valid/ready handshake.
- Gives benches an exact, in-order record of a0 transitions, including transitions shorter than the bench's sampling rate.

Parameters:
- WIDTH, 32, width of a0 and of out_value.
- DEPTH, 16, FIFO entry count; must be a power of 2 and at least 2.
- CYCLE_W, 32, width of the cycle counter and of out_cycle.

Ports:
- clk  input  1  clock; single clock domain.
- rst  input  1  synchronous reset, active-high.
- en  input  1  capture enable.
- a0  input  WIDTH  a0 value from the CPU top.
- out_ready  input  1  consumer accepts the head entry.
- out_valid  output  1  FIFO not empty.
- out_value  output  WIDTH  a0 value of the head entry.
- out_cycle  output  CYCLE_W  timestamp of the head entry.
- level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
- overflow  output  1  sticky flag: at least one entry was dropped.
- drop_count  output  16  number of dropped entries; saturates.

Behaviour:
- Reset (rst=1 at a rising edge):
  - cycle_cnt, prev_a0, read/write pointers, level, overflow and drop_count all become 0.
  - first_flag becomes 1.
  - Outputs in the following cycle: out_valid=0, out_value=0, out_cycle=0, level=0, overflow=0, drop_count=0.
  - Reset asserted mid-operation discards all queued entries with no partial drain.
- cycle_cnt:
  - Increments by 1 every non-reset cycle, independent of en.
  - Wraps from 2^CYCLE_W-1 to 0.
  - Reads 0 in the first cycle after reset deassertion.
- Change detection (combinational):
  - detect = en && (first_flag || a0 != prev_a0).
- When en=1, at each edge:
  - prev_a0 <= a0.
  - first_flag clears if detect is asserted.
- When en=0: prev_a0 and first_flag hold.
- Push:
  - On detect, entry {a0, cycle_cnt} (values of the detecting cycle) is written at the edge.
  - Latency is 1 cycle: an entry pushed into an empty FIFO gives out_valid=1 in the next cycle.
- Pop:
  - Occurs when out_valid && out_ready at the edge.
  - out_ready while empty is ignored.
- Head outputs:
  - out_value and out_cycle are driven combinationally from the head slot.
  - Both are forced to 0 when the FIFO is empty.
  - Both are stable while out_valid=1 and out_ready=0.
- Full condition (level==DEPTH):
  - Push together with pop is accepted: level stays DEPTH and nothing is dropped.
  - Push without pop is dropped: the FIFO is unchanged, overflow <= 1, and drop_count increments, saturating at 16'hFFFF.
- Simultaneous push and pop when not full: level is unchanged and both pointers advance.
- Pointers:
  - Width is $clog2(DEPTH) and they wrap naturally.
  - level is a separate counter: +1 on push only, -1 on pop only, unchanged otherwise.
- overflow and drop_count clear only on reset.
- Ordering: strictly FIFO. Entries drain in push order with non-decreasing cycle stamps, modulo counter wrap.

Decomposition:
- Shared package trace_pkg:
  - typedef trace_entry_t = packed struct {logic [WIDTH-1:0] value; logic [CYCLE_W-1:0] cycle;}, using default widths.
  - localparam DROP_MAX = 16'hFFFF.
- One natural sub-module, sync_fifo:
  - Parameterised by DATA_W and DEPTH.
  - Ports: clk, rst, push, pop, din, dout, empty, full, level.
  - Implements full-with-pop acceptance.
- a0_trace_buffer contains the cycle counter, change detector, and drop/overflow logic around sync_fifo.

Test Plan:
- First capture: reset, then en=1 with a0 held at 32'h0 → exactly one entry {0, cycle 0}, out_valid=1 from cycle 1, and no further entries over 50 cycles.
- Change sequence: drive a0 = 0, 5, 5, 9, 0 on cycles 0-4 with out_ready=1 → drained entries {0,0}, {5,1}, {9,3}, {0,4}; level never exceeds 1.
- Overflow: out_ready=0, 17 distinct a0 values on consecutive cycles (DEPTH=16) → level=16, overflow=1, drop_count=1. Then out_ready=1 drains exactly the first 16 values in order, and overflow stays 1.
- Full with concurrent pop and push: with level=16, assert out_ready=1 and change a0 in the same cycle → level stays 16, drop_count unchanged, the new value becomes the tail.
- Enable gating: en=0 while a0 goes 1→2→3, then en=1 with a0=3 and prev_a0=0 → exactly one entry {3, cycle of re-enable}.
- Reset mid-stream: level=5 and cycle_cnt=200, assert rst for one cycle → next cycle out_valid=0, level=0, overflow=0, drop_count=0, out_value=0; cycle stamps restart from 0.
